// File: rtl/memory_access_controller_if.sv
// Access-width type and the word-addressed data-memory bus between the controller
// (master) and the memory (slave).
package memory_access_controller_pkg;
  typedef enum logic [1:0] {
    MAW_BYTE = 2'd0,
    MAW_HALF = 2'd1,
    MAW_WORD = 2'd2
  } memory_access_width_t;
endpackage

interface memory_access_controller_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wdata;
  logic                  mem_rsp_valid;
  logic [31:0]           mem_rdata;

  modport master (output mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
                  input  mem_req_ready, mem_rsp_valid, mem_rdata);
  modport slave  (input  mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
                  output mem_req_ready, mem_rsp_valid, mem_rdata);
endinterface

// File: rtl/memory_access_controller.sv
// Data-memory access sequencer: aligns stores onto 32-bit lanes, splits word-crossing
// accesses into two bus transactions and returns merged, extended load data.
module memory_extension
  import memory_access_controller_pkg::*;
(
  input  logic [31:0]          i_data,
  input  memory_access_width_t i_width,
  input  logic                 i_signed,
  output logic [31:0]          o_data
);
  always_comb begin
    o_data = i_data;
    case (i_width)
      MAW_BYTE: o_data = {{24{i_signed & i_data[7]}}, i_data[7:0]};
      MAW_HALF: o_data = {{16{i_signed & i_data[15]}}, i_data[15:0]};
      default:  o_data = i_data;
    endcase
  end
endmodule

module memory_access_controller
  import memory_access_controller_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  localparam int WORD_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic [ADDR_WIDTH-1:0]      i_req_addr,
  input  logic                       i_req_write,
  input  memory_access_width_t       i_req_width,
  input  logic                       i_req_signed,
  input  logic [WORD_WIDTH-1:0]      i_req_wdata,
  output logic                       o_rsp_valid,
  output logic [WORD_WIDTH-1:0]      o_rsp_rdata,
  memory_access_controller_if.master mem_if
);
  // S_EXT registers the extended result so RESP drives it straight from a flop.
  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_EXT, S_RESP
  } state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  memory_access_width_t  r_width;
  logic                  r_signed;
  logic [31:0]           r_wdata, r_word0, r_word1, r_rsp_rdata;

  logic [1:0]            w_off;
  logic [3:0]            w_mask;
  logic [7:0]            w_be;
  logic                  w_split;
  logic [63:0]           w_data;
  logic [31:0]           w_raw, w_ext;
  logic [ADDR_WIDTH-1:0] w_base, w_base_hi;

  always_comb begin
    case (r_width)
      MAW_BYTE: w_mask = 4'b0001;
      MAW_HALF: w_mask = 4'b0011;
      default:  w_mask = 4'b1111;
    endcase
  end

  // Lane maps are built on the {hi,lo} word pair; the upper half belongs to REQ1.
  assign w_off     = r_addr[1:0];
  assign w_be      = {4'b0000, w_mask} << w_off;
  assign w_split   = |w_be[7:4];
  assign w_data    = {32'b0, r_wdata} << {w_off, 3'b000};
  assign w_raw     = 32'({r_word1, r_word0} >> {w_off, 3'b000});
  assign w_base    = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign w_base_hi = w_base + ADDR_WIDTH'(4);

  memory_extension u_ext (
    .i_data  (w_raw),
    .i_width (r_width),
    .i_signed(r_signed),
    .o_data  (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_req_valid)          w_next = S_REQ0;
      S_REQ0:  if (mem_if.mem_req_ready) w_next = S_WAIT0;
      S_WAIT0: if (mem_if.mem_rsp_valid) w_next = w_split ? S_REQ1 : S_EXT;
      S_REQ1:  if (mem_if.mem_req_ready) w_next = S_WAIT1;
      S_WAIT1: if (mem_if.mem_rsp_valid) w_next = S_EXT;
      S_EXT:                             w_next = S_RESP;
      default:                           w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready          = (r_state == S_IDLE);
    o_rsp_valid          = 1'b0;
    o_rsp_rdata          = '0;
    mem_if.mem_req_valid = 1'b0;
    mem_if.mem_addr      = '0;
    mem_if.mem_we        = 1'b0;
    mem_if.mem_be        = 4'h0;
    mem_if.mem_wdata     = 32'h0;
    case (r_state)
      S_REQ0: begin
        mem_if.mem_req_valid = 1'b1;
        mem_if.mem_addr      = w_base;
        mem_if.mem_we        = r_write;
        mem_if.mem_be        = w_be[3:0];
        mem_if.mem_wdata     = r_write ? w_data[31:0] : 32'h0;
      end
      S_REQ1: begin
        mem_if.mem_req_valid = 1'b1;
        mem_if.mem_addr      = w_base_hi;
        mem_if.mem_we        = r_write;
        mem_if.mem_be        = w_be[7:4];
        mem_if.mem_wdata     = r_write ? w_data[63:32] : 32'h0;
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_rdata = r_rsp_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_width     <= MAW_BYTE;
      r_signed    <= 1'b0;
      r_wdata     <= '0;
      r_word0     <= '0;
      r_word1     <= '0;
      r_rsp_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && i_req_valid) begin
        r_addr   <= i_req_addr;
        r_write  <= i_req_write;
        r_width  <= i_req_width;
        r_signed <= i_req_signed;
        r_wdata  <= i_req_wdata;
        r_word0  <= '0;
        r_word1  <= '0;
      end
      if (r_state == S_WAIT0 && mem_if.mem_rsp_valid) r_word0 <= mem_if.mem_rdata;
      if (r_state == S_WAIT1 && mem_if.mem_rsp_valid) r_word1 <= mem_if.mem_rdata;
      if (r_state == S_EXT) r_rsp_rdata <= r_write ? 32'h0 : w_ext;
    end
  end
endmodule

// File: tb/tb_memory_access_controller.sv
// Table-driven scoreboard bench for memory_access_controller with a one-outstanding
// memory model answering one cycle after each accepted bus request.
module tb_memory_access_controller;
  import memory_access_controller_pkg::*;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 i_req_valid, o_req_ready, i_req_write, i_req_signed, o_rsp_valid;
  logic [AW-1:0]        i_req_addr;
  memory_access_width_t i_req_width;
  logic [31:0]          i_req_wdata, o_rsp_rdata;

  logic        mem_ready, mdl_rsp, stray_rsp;
  logic [31:0] mdl_rdata;

  memory_access_controller_if #(.ADDR_WIDTH(AW)) mem_if ();
  assign mem_if.mem_req_ready = mem_ready;
  assign mem_if.mem_rsp_valid = mdl_rsp | stray_rsp;
  assign mem_if.mem_rdata     = mdl_rdata;

  memory_access_controller #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_addr(i_req_addr),
    .i_req_write(i_req_write), .i_req_width(i_req_width), .i_req_signed(i_req_signed),
    .i_req_wdata(i_req_wdata), .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata),
    .mem_if(mem_if.master)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } tx_t;
  typedef struct {
    logic [31:0] rdata;
    int          lat;
  } rsp_t;
  typedef struct {
    logic [31:0] addr; logic wr; memory_access_width_t w; logic sg; logic [31:0] wdata;
    logic [31:0] rd0, rd1; logic split;
    logic [31:0] a0; logic [3:0] be0; logic [31:0] wd0;
    logic [31:0] a1; logic [3:0] be1; logic [31:0] wd1;
    logic [31:0] exp_rd; int lat;
  } vec_t;

  tx_t         exp_tx_q[$];
  rsp_t        exp_rsp_q[$];
  logic [31:0] rdata_q[$];
  vec_t        vecs[13];

  int checks = 0, errors = 0;
  int cyc = 0, t_acc = 0, tx_cnt = 0, rsp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory model: observes handshakes, scoreboards them, answers one cycle later.
  initial begin
    tx_t e;
    logic        pend = 1'b0;
    logic [31:0] pend_data = 32'h0;
    mdl_rsp = 1'b0; mdl_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mdl_rsp = 1'b0; mdl_rdata = 32'h0;
      if (pend) begin
        mdl_rsp = 1'b1; mdl_rdata = pend_data; pend = 1'b0;
      end
      if (mem_if.mem_req_valid && mem_ready) begin
        tx_cnt++;
        if (exp_tx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx actual addr=%h required none", mem_if.mem_addr);
        end else begin
          e = exp_tx_q.pop_front();
          chk("tx_addr", mem_if.mem_addr, e.addr);
          chk("tx_we", 32'(mem_if.mem_we), 32'(e.we));
          chk("tx_be", 32'(mem_if.mem_be), 32'(e.be));
          chk("tx_wdata", mem_if.mem_wdata, e.wdata);
        end
        pend = 1'b1;
        pend_data = (rdata_q.size() != 0) ? rdata_q.pop_front() : 32'h0;
      end
    end
  end

  // Response monitor: accept time stamping and response scoreboard.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (i_req_valid && o_req_ready && !rst) t_acc = cyc;
      if (o_rsp_valid) begin
        rsp_cnt++;
        chk("ready_in_resp", 32'(o_req_ready), 32'h0);
        if (exp_rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp actual rdata=%h required none", o_rsp_rdata);
        end else begin
          e = exp_rsp_q.pop_front();
          chk("rsp_rdata", o_rsp_rdata, e.rdata);
          chk("latency", 32'(cyc - t_acc), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(o_req_ready), 32'h1);
    chk({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'h0);
    chk({tag, "_rsp_rdata"}, o_rsp_rdata, 32'h0);
    chk({tag, "_mem_req_valid"}, 32'(mem_if.mem_req_valid), 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_if.mem_we), 32'h0);
    chk({tag, "_mem_be"}, 32'(mem_if.mem_be), 32'h0);
    chk({tag, "_mem_addr"}, mem_if.mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_if.mem_wdata, 32'h0);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic wr, input memory_access_width_t w,
                       input logic sg, input logic [31:0] wd);
    bit ok = 1'b0;
    i_req_addr = a; i_req_write = wr; i_req_width = w; i_req_signed = sg; i_req_wdata = wd;
    i_req_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = o_req_ready;
      @(posedge clk); #1;
    end
    i_req_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=no_ready required=ready");
    end
  endtask

  task automatic wait_rsp(input int n0);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (rsp_cnt > n0) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rsp_timeout actual=no_rsp required=rsp");
    end else chk("ready_after_resp", 32'(o_req_ready), 32'h1);
  endtask

  task automatic run_vec(input vec_t v);
    int n0 = rsp_cnt;
    exp_tx_q.push_back(tx_t'{v.a0, v.wr, v.be0, v.wd0});
    rdata_q.push_back(v.rd0);
    if (v.split) begin
      exp_tx_q.push_back(tx_t'{v.a1, v.wr, v.be1, v.wd1});
      rdata_q.push_back(v.rd1);
    end
    exp_rsp_q.push_back(rsp_t'{v.exp_rd, v.lat});
    issue(v.addr, v.wr, v.w, v.sg, v.wdata);
    wait_rsp(n0);
  endtask

  initial begin
    int n0;
    rst = 1'b1; i_req_valid = 1'b0; i_req_addr = '0; i_req_write = 1'b0;
    i_req_width = MAW_BYTE; i_req_signed = 1'b0; i_req_wdata = 32'h0;
    mem_ready = 1'b1; stray_rsp = 1'b0;

    vecs[0]  = '{32'h100, 1'b0, MAW_WORD, 1'b0, 32'h0, 32'h800000F0, 32'h0, 1'b0, 32'h100, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 32'h800000F0, 4};
    vecs[1]  = '{32'h103, 1'b0, MAW_BYTE, 1'b1, 32'h0, 32'h80123456, 32'h0, 1'b0, 32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFFFF80, 4};
    vecs[2]  = '{32'h103, 1'b0, MAW_BYTE, 1'b0, 32'h0, 32'h80123456, 32'h0, 1'b0, 32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 32'h00000080, 4};
    vecs[3]  = '{32'h203, 1'b0, MAW_HALF, 1'b1, 32'h0, 32'hAB000000, 32'h000000CD, 1'b1, 32'h200, 4'h8, 32'h0, 32'h204, 4'h1, 32'h0, 32'hFFFFCDAB, 6};
    vecs[4]  = '{32'h0FE, 1'b1, MAW_WORD, 1'b0, 32'h11223344, 32'hDEADBEEF, 32'hFEEDFACE, 1'b1, 32'h0FC, 4'hC, 32'h33440000, 32'h100, 4'h3, 32'h00001122, 32'h0, 6};
    vecs[5]  = '{32'h001, 1'b1, MAW_BYTE, 1'b0, 32'h000000A5, 32'hDEADBEEF, 32'h0, 1'b0, 32'h000, 4'h2, 32'h0000A500, 32'h0, 4'h0, 32'h0, 32'h0, 4};
    vecs[6]  = '{32'h102, 1'b0, MAW_HALF, 1'b0, 32'h0, 32'h98760000, 32'h0, 1'b0, 32'h100, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0, 32'h00009876, 4};
    vecs[7]  = '{32'h102, 1'b0, MAW_HALF, 1'b1, 32'h0, 32'h98760000, 32'h0, 1'b0, 32'h100, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFF9876, 4};
    vecs[8]  = '{32'h010, 1'b1, MAW_HALF, 1'b0, 32'h0000BEEF, 32'hDEADBEEF, 32'h0, 1'b0, 32'h010, 4'h3, 32'h0000BEEF, 32'h0, 4'h0, 32'h0, 32'h0, 4};
    vecs[9]  = '{32'h001, 1'b0, MAW_WORD, 1'b0, 32'h0, 32'hDDCCBBAA, 32'h776655EE, 1'b1, 32'h000, 4'hE, 32'h0, 32'h004, 4'h1, 32'h0, 32'hEEDDCCBB, 6};
    vecs[10] = '{32'hFFFFFFFE, 1'b0, MAW_WORD, 1'b1, 32'h0, 32'hAAAA1111, 32'h2222BBBB, 1'b1, 32'hFFFFFFFC, 4'hC, 32'h0, 32'h000, 4'h3, 32'h0, 32'hBBBBAAAA, 6};
    vecs[11] = '{32'h002, 1'b0, MAW_BYTE, 1'b1, 32'h0, 32'h007F0000, 32'h0, 1'b0, 32'h000, 4'h4, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0000007F, 4};
    vecs[12] = '{32'h007, 1'b1, MAW_HALF, 1'b0, 32'h0000ABCD, 32'hDEADBEEF, 32'hFEEDFACE, 1'b1, 32'h004, 4'h8, 32'hCD000000, 32'h008, 4'h1, 32'h000000AB, 32'h0, 6};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Bus backpressure: REQ0 held for five extra cycles with a stable request.
    mem_ready = 1'b0;
    exp_tx_q.push_back(tx_t'{32'h300, 1'b1, 4'hF, 32'hCAFEF00D});
    rdata_q.push_back(32'h0BADF00D);
    exp_rsp_q.push_back(rsp_t'{32'h0, 9});
    n0 = rsp_cnt;
    issue(32'h300, 1'b1, MAW_WORD, 1'b0, 32'hCAFEF00D);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_req_valid", 32'(mem_if.mem_req_valid), 32'h1);
      chk("bp_addr", mem_if.mem_addr, 32'h300);
      chk("bp_wdata", mem_if.mem_wdata, 32'hCAFEF00D);
      chk("bp_be", 32'(mem_if.mem_be), 32'hF);
      chk("bp_req_ready", 32'(o_req_ready), 32'h0);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    wait_rsp(n0);

    // Reset while waiting on the second half of a split load.
    exp_tx_q.push_back(tx_t'{32'h004, 1'b0, 4'h8, 32'h0});
    exp_tx_q.push_back(tx_t'{32'h008, 1'b0, 4'h7, 32'h0});
    rdata_q.push_back(32'h11111111);
    rdata_q.push_back(32'h22222222);
    n0 = tx_cnt;
    issue(32'h007, 1'b0, MAW_WORD, 1'b1, 32'h0);
    for (int i = 0; i < 40 && tx_cnt < n0 + 2; i++) begin @(posedge clk); #1; end
    chk("rst_seq_tx_count", 32'(tx_cnt), 32'(n0 + 2));
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    stray_rsp = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stray_rsp_valid", 32'(o_rsp_valid), 32'h0);
      chk("stray_req_ready", 32'(o_req_ready), 32'h1);
    end
    @(posedge clk); #1;
    stray_rsp = 1'b0;
    @(posedge clk); #1;
    run_vec(vecs[0]);

    repeat (4) @(posedge clk);
    #1;
    chk("tx_queue_drained", 32'(exp_tx_q.size()), 32'h0);
    chk("rsp_queue_drained", 32'(exp_rsp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_access_controller.md
# memory_access_controller

Sequences every data-memory access issued by the execute stage. Accepts one load/store request at a time, aligns store data and byte enables onto a 32-bit word-addressed memory port, and splits accesses that cross a word boundary into two memory transactions. Merges load data and passes it through an internal `memory_extension` instance so `rsp_rdata` is already zero- or sign-extended. Sits between the datapath and the data-memory bus; `req_ready` low stalls the pipeline.

## Interface
- `ADDR_WIDTH`, default 32: byte-address width.
- `clk  in  1`: clock; all state updates on rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `req_valid  in  1`: datapath presents an access.
- `req_ready  out  1`: controller can accept; high only in IDLE.
- `req_addr  in  ADDR_WIDTH`: byte address.
- `req_write  in  1`: 1 = store, 0 = load.
- `req_width  in  memory_access_width_t`: BYTE/HALF/WORD (1/2/4 bytes).
- `req_signed  in  1`: sign-extend load result; ignored for stores.
- `req_wdata  in  WORD_WIDTH`: store data, right-aligned.
- `rsp_valid  out  1`: one-cycle completion pulse (loads and stores).
- `rsp_rdata  out  WORD_WIDTH`: extended load data; 0 for stores.
- `mem_req_valid  out  1`, `mem_req_ready  in  1`: memory request handshake.
- `mem_addr  out  ADDR_WIDTH`: word-aligned address, bits [1:0] = 0.
- `mem_we  out  1`, `mem_be  out  4`, `mem_wdata  out  32`: write enable, byte enables, lane-aligned write data.
- `mem_rsp_valid  in  1`, `mem_rdata  in  32`: read/write acknowledge and read data.

## Operation
- Definitions: `off` = addr[1:0]; `n` = byte count of width; `split` = (off + n > 4).
- Request fires when `req_valid && req_ready`; all req_* fields are registered then. Inputs are ignored in every other state.
- States: IDLE -> REQ0 -> WAIT0 -> (split ? REQ1 -> WAIT1 :) -> RESP -> IDLE.
- REQ0: `mem_req_valid`=1, `mem_addr` = addr & ~3. Held stable until `mem_req_ready`, then WAIT0.
- REQ1: same, with `mem_addr` = (addr & ~3) + 4. Wraps modulo 2^ADDR_WIDTH.
- WAITx: waits for `mem_rsp_valid` and captures `mem_rdata` into word0/word1. `mem_rsp_valid` outside WAITx is ignored.
- Store lane mapping on the 64-bit concatenation {hi,lo}:
  - data = zero-extended wdata << (8*off);
  - be = ((1<<n)-1) << off.
  - REQ0 drives lo (be[3:0], data[31:0]); REQ1 drives hi (be[7:4], data[63:32]).
  - `mem_we` = req_write in both.
- Load merge: raw = ({word1, word0} >> 8*off)[31:0], with word1 = 0 when not split. raw feeds `memory_extension` with registered width/signed. Reads drive `mem_be` = the same mask as stores, `mem_wdata` = 0.
- RESP: `rsp_valid`=1 for exactly one cycle with `rsp_rdata` valid. No backpressure. Next state IDLE.
- All non-RESP states: `rsp_valid`=0, `rsp_rdata`=0.

## Timing
- Reset values: state IDLE; `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `mem_req_valid`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0.
- Minimum latency, with `mem_req_ready` high and `mem_rsp_valid` arriving 1 cycle after accept:
  - Aligned access: accept at cycle 0, `rsp_valid` at cycle 4 (REQ0 c1, WAIT0 c2, capture at c3 edge, RESP c4 — RESP is one registered cycle after last capture).
  - Split access: `rsp_valid` at cycle 6.
- Throughput: one request per (latency + 1) cycles. `req_ready` rises the cycle after RESP.
- Memory side guarantees in-order responses, at most one outstanding. A `mem_rsp_valid` in the same cycle as REQx's handshake is not accepted; response must be at least one cycle after.
- `rst` mid-operation: next cycle returns to IDLE with reset outputs. The in-flight transaction is abandoned, and a later stray `mem_rsp_valid` in IDLE is ignored.
- `req_valid` during RESP is not accepted (`req_ready`=0).

## Test plan
- Aligned load word: addr 0x100, WORD, mem_rdata 0x8000_00F0 -> one mem request addr 0x100, be 0xF, rsp_rdata 0x8000_00F0, rsp_valid exactly cycle 4.
- Byte loads: addr 0x103, BYTE, mem_rdata 0x80xx_xxxx -> signed rsp_rdata 0xFFFF_FF80, unsigned 0x0000_0080, single transaction, be 0x8.
- Split load half: addr 0x203, HALF, signed, word0 0xAB00_0000, word1 0x0000_00CD -> mem addrs 0x200 then 0x204, rsp_rdata 0xFFFF_CDAB.
- Split store word: addr 0x0FE, WORD, wdata 0x1122_3344 -> tx0 addr 0x0FC, be 0xC, wdata 0x3344_0000; tx1 addr 0x100, be 0x3, wdata 0x0000_1122; rsp_valid with rsp_rdata 0.
- Backpressure: hold mem_req_ready low 5 cycles in REQ0 -> mem_addr/mem_wdata/mem_be stable, req_ready 0, completion delayed by 5 cycles.
- Reset mid-op: assert rst in WAIT1 of a split load -> next cycle all outputs at reset values, req_ready 1; a later stray mem_rsp_valid yields no rsp_valid; next aligned request completes correctly.
